// File: rtl/rv_pkg.sv
// Shared RISC-V core types.
// Fetch-stage bundle and FSM encoding.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch buffer of fetch_entry_t.
// Flush empties it; push and pop may coincide.
module fetch_queue
  import rv_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int AW = $clog2(QDEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [AW:0]  count
);

  fetch_entry_t mem [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  // Pointers and occupancy; flush drops everything.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, fault FSM,
// fetch queue and decode handshake.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_DEPTH = 512,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  logic [31:0]   pc;
  fetch_state_t  state, state_nx;
  fetch_entry_t  head;
  fetch_entry_t  wentry;
  logic [CW-1:0] count;
  logic          pc_bad;
  logic          enq;
  logic          deq;
  logic [31:0]   hold_instr;
  logic [31:0]   hold_pc;
  logic [31:0]   hold_plus4;

  assign imem_pc  = pc;
  assign pc_bad   = (pc[1:0] != 2'b00) ||
                    (pc[31:2] >= DEPTH_W);
  assign id_valid = (count != '0);
  assign deq      = id_valid && id_ready &&
                    !redirect_valid;
  assign enq      = !pc_bad && (state == FETCH) &&
                    !redirect_valid &&
                    ((count != QFULL) || deq);
  assign wentry   = '{pc: pc, instr: imem_instr};

  fetch_queue #(.QDEPTH(QDEPTH)) u_q (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (enq),
    .pop   (deq),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  // PC: redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (enq) begin
      pc <= pc + 32'd4;
    end
  end

  // Fault state register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  // Halt on a bad PC; only a redirect resumes.
  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH: if (!redirect_valid && pc_bad) state_nx = HALT;
      HALT:  if (redirect_valid)            state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  assign fetch_fault = (state == HALT);

  // Remember last head so outputs hold when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_instr <= '0;
      hold_pc    <= '0;
      hold_plus4 <= '0;
    end else if (id_valid) begin
      hold_instr <= head.instr;
      hold_pc    <= head.pc;
      hold_plus4 <= head.pc + 32'd4;
    end
  end

  assign id_instr    = id_valid ? head.instr : hold_instr;
  assign id_pc       = id_valid ? head.pc : hold_pc;
  assign id_pc_plus4 = id_valid ? head.pc + 32'd4
                                : hold_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Inputs driven and outputs sampled on negedge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;

  logic [31:0] imem [512];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (512),
    .QDEPTH     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  always_comb begin
    imem_instr = 32'h0;
    if (imem_pc[31:11] == '0) imem_instr = imem[imem_pc[10:2]];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag,
                          input logic [31:0] pc,
                          input logic [31:0] ins);
    chk({tag, "_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_instr"}, id_instr, ins);
    chk({tag, "_plus4"}, id_pc_plus4, pc + 32'd4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_pc"}, id_pc, 32'h0);
    chk({tag, "_instr"}, id_instr, 32'h0);
    chk({tag, "_plus4"}, id_pc_plus4, 32'h0);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, "_imem_pc"}, imem_pc, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++)
      imem[i] = 32'h0013_0000 | (i << 2);
    imem[0] = 32'hf9c0_0393;
    imem[1] = 32'hff63_a313;

    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b1;
    repeat (3) cyc();
    chk_reset("rst");

    // 1: back-to-back delivery
    reset = 1'b0;
    cyc();
    chk_head("t1_c1", 32'h0, 32'hf9c0_0393);
    chk("t1_imem_pc1", imem_pc, 32'h4);
    cyc();
    chk_head("t1_c2", 32'h4, 32'hff63_a313);
    chk("t1_imem_pc2", imem_pc, 32'h8);

    // 2: back-pressure from a fresh reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    id_ready = 1'b0;
    repeat (5) cyc();
    chk("t2_imem_pc", imem_pc, 32'h8);
    chk_head("t2_held", 32'h0, 32'hf9c0_0393);
    chk("t2_count", 32'(dut.u_q.count), 32'd2);
    id_ready = 1'b1;
    cyc();
    chk_head("t2_r1", 32'h4, 32'hff63_a313);
    cyc();
    chk_head("t2_r2", 32'h8, 32'h0013_0008);
    chk("t2_imem_pc2", imem_pc, 32'h10);

    // 3: redirect with full queue and ready
    chk("t3_count", 32'(dut.u_q.count), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    chk("t3_valid", 32'(id_valid), 32'd0);
    chk("t3_imem_pc", imem_pc, 32'h40);
    cyc();
    chk_head("t3_tgt", 32'h40, 32'h0013_0040);

    // 4: misaligned redirect, then recovery
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_fault0", 32'(fetch_fault), 32'd0);
    chk("t4_valid0", 32'(id_valid), 32'd0);
    cyc();
    chk("t4_fault1", 32'(fetch_fault), 32'd1);
    chk("t4_valid1", 32'(id_valid), 32'd0);
    cyc();
    chk("t4_fault2", 32'(fetch_fault), 32'd1);
    chk("t4_imem_pc", imem_pc, 32'h42);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_clear", 32'(fetch_fault), 32'd0);
    cyc();
    chk_head("t4_tgt", 32'h10, 32'h0013_0010);

    // 5: run off the end of imem
    redirect_valid = 1'b1;
    redirect_pc = 32'h7F8;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk_head("t5_7f8", 32'h7F8, 32'h0013_07F8);
    cyc();
    chk_head("t5_7fc", 32'h7FC, 32'h0013_07FC);
    chk("t5_imem_pc", imem_pc, 32'h800);
    chk("t5_fault0", 32'(fetch_fault), 32'd0);
    cyc();
    chk("t5_fault1", 32'(fetch_fault), 32'd1);
    chk("t5_valid", 32'(id_valid), 32'd0);
    chk("t5_last_pc", id_pc, 32'h7FC);
    chk("t5_imem_hold", imem_pc, 32'h800);
    cyc();
    chk("t5_sticky", 32'(fetch_fault), 32'd1);

    // 6: reset beats redirect and handshake
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    cyc();
    redirect_valid = 1'b0;
    repeat (3) cyc();
    chk("t6_full", 32'(dut.u_q.count), 32'd2);
    chk("t6_imem_pc", imem_pc, 32'h8);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    id_ready = 1'b1;
    cyc();
    chk_reset("t6_rst");
    reset = 1'b0;
    redirect_valid = 1'b0;
    cyc();
    chk_head("t6_restart", 32'h0, 32'hf9c0_0393);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
